alu_op_sequencer: RTL

- Controller that drives the 3-bit ALU operation select for the board datapath, replacing the plain button-stepped select FSM.
- Four modes: manual stepping from the debounced button tick, timed auto-cycling, a one-shot sweep that runs all 8 ops and streams each captured result to a result bank, and hold.
- Sits between the debouncer and the clocked ALU. Its sweep write port feeds the display and result register bank.

---
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Drives the 3-bit ALU operation select for the board datapath. Four modes:
//   manual stepping on the debounced button tick, timed auto-cycling, a
//   one-shot sweep that walks all 8 ops and streams each captured ALU result
//   to the result bank, and hold.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_tick     one-cycle debounced button pulse
//   mode         00 manual, 01 auto, 10 sweep, 11 hold
//   start        sweep start pulse (only looked at in mode 10, while idle)
//   alu_out      result from the clocked ALU
//   sel          ALU operation select
//   result_wr    one-cycle write strobe to the result bank
//   result_addr  op index of result_data
//   result_data  captured alu_out
//   busy         high while a sweep runs
//   done         one-cycle pulse when a sweep completes
//
// All outputs are registered.

module alu_op_sequencer #(
    parameter int DWELL   = 50_000_000,
    parameter int ALU_LAT = 1,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_tick,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic [DATA_W-1:0] alu_out,
    output logic [2:0]        sel,
    output logic              result_wr,
    output logic [2:0]        result_addr,
    output logic [DATA_W-1:0] result_data,
    output logic              busy,
    output logic              done
);

    localparam int DW_W = $clog2(DWELL);
    localparam int WT_W = $clog2(ALU_LAT + 1);

    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [WT_W-1:0] WAIT_LAST  = WT_W'(ALU_LAT);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;

    typedef enum logic [1:0] {IDLE, SW_WAIT, SW_CAPT, SW_DONE} state_t;

    state_t            state, state_n;
    logic [DW_W-1:0]   dwell_cnt, dwell_n;
    logic [WT_W-1:0]   wait_cnt, wait_n, wait_inc;
    logic [2:0]        sel_n, addr_n;
    logic [DATA_W-1:0] data_n;
    logic              wr_n, busy_n, done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dwell_cnt   <= '0;
            wait_cnt    <= '0;
            sel         <= '0;
            result_wr   <= 1'b0;
            result_addr <= '0;
            result_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            dwell_cnt   <= dwell_n;
            wait_cnt    <= wait_n;
            sel         <= sel_n;
            result_wr   <= wr_n;
            result_addr <= addr_n;
            result_data <= data_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        dwell_n  = dwell_cnt;
        wait_n   = wait_cnt;
        sel_n    = sel;
        wr_n     = 1'b0;
        addr_n   = result_addr;
        data_n   = result_data;
        busy_n   = busy;
        done_n   = 1'b0;
        wait_inc = wait_cnt + WT_W'(1);

        case (state)
            IDLE: begin
                busy_n  = 1'b0;
                // Only auto mode keeps the dwell count alive; any other mode
                // parks it at 0 so re-entering auto starts a fresh period.
                dwell_n = '0;
                case (mode)
                    MODE_MANUAL: begin
                        if (btn_tick) sel_n = sel + 3'd1;
                    end
                    MODE_AUTO: begin
                        if (dwell_cnt == DWELL_LAST) sel_n = sel + 3'd1;
                        else                         dwell_n = dwell_cnt + DW_W'(1);
                    end
                    MODE_SWEEP: begin
                        // done is still high on the first idle cycle after a
                        // sweep; a start seen then is left untaken.
                        if (start && !done) begin
                            sel_n   = 3'd0;
                            busy_n  = 1'b1;
                            wait_n  = '0;
                            state_n = SW_WAIT;
                        end
                    end
                    default: ;  // hold: sel frozen
                endcase
            end
            SW_WAIT: begin
                // Leaving on the edge where the count reaches ALU_LAT makes the
                // capture edge land exactly ALU_LAT+1 edges after sel changed.
                wait_n = wait_inc;
                if (wait_inc == WAIT_LAST) state_n = SW_CAPT;
            end
            SW_CAPT: begin
                wr_n   = 1'b1;
                addr_n = sel;
                data_n = alu_out;
                if (sel == 3'd7) begin
                    state_n = SW_DONE;
                end else begin
                    sel_n   = sel + 3'd1;
                    wait_n  = '0;
                    state_n = SW_WAIT;
                end
            end
            SW_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                sel_n   = 3'd0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
